// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - clock-enable run controller and CPU output latch bank
// Optional BREAKPOINT_EN adds the PC breakpoint and HALT state.
module cpu_run_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int PC_W      = 15,
  parameter int DIV_RATIO = 2,
  parameter int CNT_W     = 8,
  parameter int NUM_CHAN  = 4,
  parameter int BASE_ADDR = 2,
  localparam int SEL_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run_mode,
  input  logic                       step_pulse,
  input  logic [CNT_W-1:0]           burst_len,
  input  logic [PC_W-1:0]            pc,
  input  logic [PC_W-1:0]            bp_addr,
  input  logic                       bp_enable,
  input  logic                       writeM,
  input  logic [ADDR_W-1:0]          addressM,
  input  logic [DATA_W-1:0]          outM,
  input  logic [SEL_W-1:0]           chan_sel,
  output logic                       cpu_ce,
  output logic                       halted,
  output logic [1:0]                 state,
  output logic [NUM_CHAN*DATA_W-1:0] chan_data,
  output logic [DATA_W-1:0]          led_out
);

  localparam logic [1:0] S_MANUAL = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_BURST  = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam int PRE_W = $clog2(DIV_RATIO);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_RATIO - 1);

  logic [PRE_W-1:0]  pre;
  logic [CNT_W-1:0]  burst_cnt;
  logic              tick;
  logic              bp_hit;
  logic [DATA_W-1:0] lat [NUM_CHAN];

  assign tick = (state == S_RUN || state == S_BURST) && (pre == PRE_LAST);

`ifdef BREAKPOINT_EN
  assign bp_hit = bp_enable && (pc == bp_addr);
`else
  // Without the breakpoint, HALT is never entered and halted stays 0.
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_enable, pc};
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_MANUAL;
      cpu_ce    <= 1'b0;
      halted    <= 1'b0;
      pre       <= '0;
      burst_cnt <= '0;
    end else begin
      cpu_ce <= 1'b0;
      if (state == S_RUN || state == S_BURST)
        pre <= tick ? '0 : pre + PRE_W'(1);
      case (state)
        S_MANUAL: begin
          if (run_mode) begin
            state <= S_RUN;
            pre   <= '0;
          end else if (step_pulse) begin
            if (burst_len <= CNT_W'(1)) begin
              cpu_ce <= 1'b1;
            end else begin
              state     <= S_BURST;
              burst_cnt <= burst_len;
              pre       <= '0;
            end
          end
        end
        S_RUN: begin
          if (!run_mode) begin
            state <= S_MANUAL;
          end else if (tick) begin
            if (bp_hit) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              cpu_ce <= 1'b1;
            end
          end
        end
        S_BURST: begin
          if (tick) begin
            if (bp_hit) begin
              state     <= S_HALT;
              halted    <= 1'b1;
              burst_cnt <= '0;
            end else begin
              cpu_ce    <= 1'b1;
              burst_cnt <= burst_cnt - CNT_W'(1);
              if (burst_cnt == CNT_W'(1))
                state <= S_MANUAL;
            end
          end
        end
        default: begin
          // Stepping out of HALT executes the breakpoint instruction itself.
          if (step_pulse) begin
            cpu_ce <= 1'b1;
            halted <= 1'b0;
            pre    <= '0;
            state  <= run_mode ? S_RUN : S_MANUAL;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    logic hit;
    assign hit = cpu_ce && writeM && (32'(addressM) == 32'(BASE_ADDR + i));

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        lat[i] <= '0;
      else if (hit)
        lat[i] <= outM;
    end

    assign chan_data[i*DATA_W +: DATA_W] = lat[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      led_out <= '0;
    else if (32'(chan_sel) < NUM_CHAN)
      led_out <= lat[chan_sel];
    else
      led_out <= '0;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - randomized and directed bench for cpu_run_ctrl
// Reference model tracks cycles-since-entry and remaining steps; honours BREAKPOINT_EN.
module tb_cpu_run_ctrl;

  localparam int DIV  = 4;
  localparam int NCH  = 4;
  localparam int BASE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_mode, step_pulse, bp_enable, writeM;
  logic [7:0]  burst_len;
  logic [14:0] pc, bp_addr, addressM;
  logic [15:0] outM;
  logic [1:0]  chan_sel;
  logic        cpu_ce, halted;
  logic [1:0]  state;
  logic [63:0] chan_data;
  logic [15:0] led_out;

  cpu_run_ctrl #(.DIV_RATIO(DIV)) dut (
    .clk(clk), .reset(reset), .run_mode(run_mode), .step_pulse(step_pulse),
    .burst_len(burst_len), .pc(pc), .bp_addr(bp_addr), .bp_enable(bp_enable),
    .writeM(writeM), .addressM(addressM), .outM(outM), .chan_sel(chan_sel),
    .cpu_ce(cpu_ce), .halted(halted), .state(state), .chan_data(chan_data),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ce_cnt  = 0;

  // model: mode uses the externally visible state numbering
  int          m_mode, m_since, m_left;
  bit          m_ce, m_halt;
  logic [15:0] m_lat [NCH];
  logic [15:0] m_led;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_pack();
    logic [63:0] v;
    for (int i = 0; i < NCH; i++) v[i*16 +: 16] = m_lat[i];
    return v;
  endfunction

  task automatic model_step();
    bit   n_ce, bp;
    int   a;
    if (reset) begin
      m_mode = 0; m_since = 0; m_left = 0; m_ce = 0; m_halt = 0; m_led = '0;
      for (int i = 0; i < NCH; i++) m_lat[i] = '0;
      return;
    end
`ifdef BREAKPOINT_EN
    bp = bp_enable && (pc == bp_addr);
`else
    bp = 1'b0;
`endif
    m_led = (int'(chan_sel) < NCH) ? m_lat[chan_sel] : 16'h0;
    a = int'(addressM);
    if (m_ce && writeM && a >= BASE && a < BASE + NCH) m_lat[a - BASE] = outM;
    n_ce = 0;
    case (m_mode)
      0: if (run_mode) begin m_mode = 1; m_since = 0; end
         else if (step_pulse) begin
           if (burst_len <= 1) n_ce = 1;
           else begin m_mode = 2; m_left = int'(burst_len); m_since = 0; end
         end
      1: if (!run_mode) m_mode = 0;
         else begin
           m_since++;
           if (m_since % DIV == 0) begin
             if (bp) begin m_mode = 3; m_halt = 1; end else n_ce = 1;
           end
         end
      2: begin
           m_since++;
           if (m_since % DIV == 0) begin
             if (bp) begin m_mode = 3; m_halt = 1; m_left = 0; end
             else begin
               n_ce = 1; m_left--;
               if (m_left == 0) m_mode = 0;
             end
           end
         end
      default: if (step_pulse) begin
           n_ce = 1; m_halt = 0; m_since = 0;
           m_mode = run_mode ? 1 : 0;
         end
    endcase
    m_ce = n_ce;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (cpu_ce) ce_cnt++;
    check("cpu_ce", 64'(cpu_ce), 64'(m_ce));
    check("state", 64'(state), 64'(m_mode));
    check("halted", 64'(halted), 64'(m_halt));
    check("led_out", 64'(led_out), 64'(m_led));
    check("chan_data", chan_data, m_pack());
  endtask

  task automatic drive_random();
    if ($urandom_range(0, 39) == 0) run_mode = ~run_mode;
    step_pulse = !step_pulse && ($urandom_range(0, 7) == 0);
    burst_len  = 8'($urandom_range(0, 5));
    pc         = 15'($urandom_range(0, 7));
    bp_enable  = ($urandom_range(0, 3) != 0);
    writeM     = 1'($urandom_range(0, 1));
    addressM   = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 7));
    outM       = 16'($urandom);
    chan_sel   = 2'($urandom);
  endtask

  initial begin
    reset = 1'b1; run_mode = 0; step_pulse = 0; burst_len = '0; pc = '0;
    bp_addr = 15'd5; bp_enable = 0; writeM = 0; addressM = '0; outM = '0; chan_sel = '0;
    cycle(); cycle();
    check("rst_state", 64'(state), 64'd0);
    check("rst_ce", 64'(cpu_ce), 64'd0);
    check("rst_chan", chan_data, 64'd0);
    reset = 1'b0;
    cycle();

    // single step
    ce_cnt = 0; step_pulse = 1; burst_len = 8'd0;
    cycle();
    check("t1_ce_next", 64'(cpu_ce), 64'd1);
    step_pulse = 0;
    repeat (5) cycle();
    check("t1_ce_count", 64'(ce_cnt), 64'd1);

    // free run: 20 cycles -> 5 enables
    ce_cnt = 0; run_mode = 1;
    cycle();
    ce_cnt = 0;
    repeat (20) cycle();
    check("t2_run_count", 64'(ce_cnt), 64'd5);
    run_mode = 0; ce_cnt = 0;
    repeat (10) cycle();
    check("t2_stop_count", 64'(ce_cnt), 64'd0);

    // burst of 3 with an ignored step in the middle
    ce_cnt = 0; burst_len = 8'd3; step_pulse = 1;
    cycle();
    step_pulse = 0;
    repeat (5) cycle();
    step_pulse = 1; cycle(); step_pulse = 0;
    repeat (12) cycle();
    check("t3_burst_count", 64'(ce_cnt), 64'd3);
    check("t3_state", 64'(state), 64'd0);

`ifdef BREAKPOINT_EN
    bp_enable = 1; bp_addr = 15'd5; pc = 15'd5; run_mode = 1;
    for (int k = 0; k < 20 && m_mode != 3; k++) cycle();
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_state", 64'(state), 64'd3);
    step_pulse = 1; cycle(); step_pulse = 0; pc = 15'd6;
    check("t4_step_ce", 64'(cpu_ce), 64'd1);
    cycle();
    check("t4_resume", 64'(state), 64'd1);
    run_mode = 0; bp_enable = 0;
    repeat (3) cycle();
`endif

    // latch write gated by cpu_ce, readback, out-of-window write
    burst_len = 8'd0; writeM = 1; addressM = 15'd3; outM = 16'hBEEF; step_pulse = 1;
    cycle();
    step_pulse = 0;
    cycle();
    outM = 16'h1234;
    cycle();
    chan_sel = 2'd1;
    cycle(); cycle();
    check("t5_chan1", 64'(chan_data[31:16]), 64'h0000_0000_0000_BEEF);
    check("t5_led", 64'(led_out), 64'h0000_0000_0000_BEEF);
    addressM = 15'd6; outM = 16'h5555; step_pulse = 1;
    cycle();
    step_pulse = 0;
    cycle();
    writeM = 0;
    cycle();
    check("t5_addr6", chan_data, 64'h0000_0000_BEEF_0000);

    // async reset in the middle of a burst, right after an enable
    burst_len = 8'd5; step_pulse = 1;
    cycle();
    step_pulse = 0;
    for (int k = 0; k < 20 && !m_ce; k++) cycle();
    check("t6_pre_ce", 64'(cpu_ce), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_ce", 64'(cpu_ce), 64'd0);
    check("t6_state", 64'(state), 64'd0);
    check("t6_chan", chan_data, 64'd0);
    cycle();
    reset = 1'b0; ce_cnt = 0;
    repeat (12) cycle();
    check("t6_quiet", 64'(ce_cnt), 64'd0);

    for (int k = 0; k < 3000; k++) begin
      drive_random();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
